// File: rtl/output_port_buffer_pkg.sv
// Shared router constants: default flit width, port direction labels and allocator register slack.
package output_port_buffer_pkg;

    localparam int DATASIZE   = 30;
    localparam int DEPTH      = 4;
    localparam int WIDTH      = 2;
    localparam int FULL_SLACK = 1;

    typedef enum logic [4:0] {
        DIR_L = 5'b00001,
        DIR_W = 5'b00010,
        DIR_N = 5'b00100,
        DIR_E = 5'b01000,
        DIR_S = 5'b10000
    } dir_e;

    // Occupancy at which backpressure asserts, leaving room for flits already in flight.
    function automatic int full_level(input int depth);
        return depth - FULL_SLACK;
    endfunction

endpackage

// File: rtl/output_port_buffer_sync_fifo.sv
// Flop-based first-word-fall-through FIFO; a write into an empty FIFO is visible on head after one edge.
// Writes at capacity are ignored unless a read frees the slot on the same edge.
module output_port_buffer_sync_fifo #(
    parameter int DATASIZE = 30,
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] head,
    output logic [WIDTH:0]      count
);

    localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH+1)'(DEPTH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic                rd_ok;
    logic                wr_ok;

    assign rd_ok = rd_en && (count != '0);
    assign wr_ok = wr_en && ((count != DEPTH_CNT) || rd_ok);
    assign head  = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + WIDTH'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (WIDTH+1)'(1);
                2'b01:   count <= count - (WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_port_buffer.sv
// Output queue between switch allocator and link: 1-cycle write-to-link latency when empty, valid/ready on the link.
// full asserts one entry early so the flit already loaded in the allocator register always has a slot.
module output_port_buffer
    import output_port_buffer_pkg::*;
#(
    parameter int DATASIZE = output_port_buffer_pkg::DATASIZE,
    parameter int DEPTH    = output_port_buffer_pkg::DEPTH,
    parameter int WIDTH    = output_port_buffer_pkg::WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                full,
    output logic                out_valid,
    output logic [DATASIZE-1:0] out_data,
    input  logic                out_ready,
    output logic [WIDTH:0]      count,
    output logic                overflow
);

    localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] FULL_CNT  = (WIDTH+1)'(full_level(DEPTH));

    logic load_q;
    logic write_en;
    logic rd_en;

    // The allocator only reloads on edges where full was low, so a held flit is new exactly once.
    assign write_en  = in_valid & load_q;
    assign out_valid = (count != '0);
    assign rd_en     = out_valid & out_ready;
    assign full      = (count >= FULL_CNT);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            load_q   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            load_q <= ~full;
            if (write_en && (count == DEPTH_CNT) && !rd_en) begin
                overflow <= 1'b1;
            end
        end
    end

    output_port_buffer_sync_fifo #(
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (write_en),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .head    (out_data),
        .count   (count)
    );

endmodule
